// File: rtl/xbar_sched_pkg.sv
// Shared types and width helpers for the crossbar packet scheduler.
package xbar_sched_pkg;

    typedef enum logic {IDLE, LOCKED} xbar_sched_state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_sched_if.sv
// Requester/output handshake bundle between the crossbar datapath side and the scheduler.
interface xbar_sched_if
    import xbar_sched_pkg::*;
#(
    parameter int NUM_INPUT  = 4,
    parameter int NUM_OUTPUT = 4
);
    localparam int SEL_W  = idx_width(NUM_INPUT);
    localparam int DEST_W = idx_width(NUM_OUTPUT);

    logic [NUM_INPUT-1:0]                  req_valid;
    logic [NUM_INPUT-1:0][DEST_W-1:0]      req_dest;
    logic [NUM_INPUT-1:0]                  req_last;
    logic [NUM_INPUT-1:0]                  req_ready;
    logic [NUM_OUTPUT-1:0]                 out_valid;
    logic [NUM_OUTPUT-1:0]                 out_ready;
    logic [NUM_OUTPUT-1:0][SEL_W-1:0]      select_vector;

    modport master (
        output req_valid, req_dest, req_last, out_ready,
        input  req_ready, out_valid, select_vector
    );

    modport slave (
        input  req_valid, req_dest, req_last, out_ready,
        output req_ready, out_valid, select_vector
    );

endinterface

// File: rtl/xbar_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr, wrapping.
module rr_arbiter
    import xbar_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan farthest-first so the candidate closest to ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/xbar_sched.sv
// Crossbar packet scheduler: one round-robin arbiter per output, grant held for a whole packet.
module xbar_sched
    import xbar_sched_pkg::*;
#(
    parameter int NUM_INPUT  = 4,
    parameter int NUM_OUTPUT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    xbar_sched_if.slave bus
);

    localparam int SEL_W = idx_width(NUM_INPUT);

    xbar_sched_state_e                 state [NUM_OUTPUT];
    logic [NUM_OUTPUT-1:0][SEL_W-1:0]  sel;
    logic [NUM_OUTPUT-1:0][SEL_W-1:0]  rr_ptr;
    logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] match;
    logic [NUM_OUTPUT-1:0]             grant_valid;
    logic [NUM_OUTPUT-1:0][SEL_W-1:0]  grant_idx;

    // Out-of-range destinations never equal any output index, so they never win.
    always_comb begin
        match = '0;
        for (int o = 0; o < NUM_OUTPUT; o++) begin
            for (int i = 0; i < NUM_INPUT; i++) begin
                match[o][i] = bus.req_valid[i] && (int'(bus.req_dest[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_arb
        rr_arbiter #(.NUM_REQ(NUM_INPUT)) u_arb (
            .req         (match[o]),
            .ptr         (rr_ptr[o]),
            .grant_valid (grant_valid[o]),
            .grant_idx   (grant_idx[o])
        );
    end

    // NOTE: sequential state uses <= only, so every output FSM sees pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int o = 0; o < NUM_OUTPUT; o++) begin
                state[o] <= IDLE;
            end
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            for (int o = 0; o < NUM_OUTPUT; o++) begin
                case (state[o])
                    IDLE: begin
                        if (grant_valid[o]) begin
                            sel[o]   <= grant_idx[o];
                            state[o] <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (bus.req_valid[sel[o]] && bus.out_ready[o] && bus.req_last[sel[o]]) begin
                            state[o]  <= IDLE;
                            rr_ptr[o] <= (int'(sel[o]) == NUM_INPUT - 1) ? '0 : sel[o] + SEL_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // An input targets one output at a time, so at most one output ever drives its ready bit.
    always_comb begin
        bus.out_valid = '0;
        bus.req_ready = '0;
        for (int o = 0; o < NUM_OUTPUT; o++) begin
            if (!rst_i && state[o] == LOCKED) begin
                bus.out_valid[o] = bus.req_valid[sel[o]];
                if (bus.out_ready[o]) begin
                    bus.req_ready[sel[o]] = 1'b1;
                end
            end
        end
    end

    assign bus.select_vector = sel;

endmodule

// File: tb/tb_xbar_sched.sv
// Directed self-checking bench for xbar_sched with 4 inputs and 4 outputs.
module tb_xbar_sched;
    import xbar_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   beats1 = 0;
    int   exp_rr [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    xbar_sched_if #(.NUM_INPUT(4), .NUM_OUTPUT(4)) bus ();

    xbar_sched #(.NUM_INPUT(4), .NUM_OUTPUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Beats accepted on output 1, counted at the edge where they transfer.
    always @(posedge clk) begin
        if (bus.out_valid[1] && bus.out_ready[1]) beats1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with every requester active toward output 0.
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_dest  = '0;
        bus.req_last  = 4'hF;
        bus.out_ready = 4'hF;
        for (int c = 0; c < 2; c++) begin
            next();
            check("rst_out_valid", 32'(bus.out_valid), 32'h0);
            check("rst_req_ready", 32'(bus.req_ready), 32'h0);
            check("rst_select", 32'(bus.select_vector), 32'h0);
        end
        rst = 1'b0;
        next();
        check("first_grant_valid", 32'(bus.out_valid), 32'b0001);
        check("first_grant_ready", 32'(bus.req_ready), 32'b0001);
        check("first_grant_sel0", 32'(bus.select_vector[0]), 32'd0);
        next();
        check("first_release_valid", 32'(bus.out_valid), 32'h0);
        bus.req_valid = 4'h0;

        // Round robin of single-beat packets on output 2.
        for (int i = 0; i < 4; i++) bus.req_dest[i] = 2'd2;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            next();
            check("rr_sel2", 32'(bus.select_vector[2]), 32'(exp_rr[k]));
            check("rr_valid", 32'(bus.out_valid), 32'b0100);
            check("rr_ready", 32'(bus.req_ready), 32'(1 << exp_rr[k]));
            next();
            check("rr_bubble_valid", 32'(bus.out_valid), 32'h0);
            check("rr_bubble_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid = 4'h0;

        // Packet lock: input 1 sends 3 beats to output 0; input 3 joins at beat 2.
        bus.req_dest[1] = 2'd0;
        bus.req_last    = 4'b0000;
        bus.req_valid   = 4'b0010;
        next();
        check("lock_sel_b1", 32'(bus.select_vector[0]), 32'd1);
        check("lock_ready_b1", 32'(bus.req_ready), 32'b0010);
        check("lock_valid_b1", 32'(bus.out_valid), 32'b0001);
        next();
        bus.req_dest[3] = 2'd0;
        bus.req_valid   = 4'b1010;
        #1;
        check("lock_sel_b2", 32'(bus.select_vector[0]), 32'd1);
        check("lock_ready_b2", 32'(bus.req_ready), 32'b0010);
        next();
        bus.req_last = 4'b1010;
        #1;
        check("lock_sel_b3", 32'(bus.select_vector[0]), 32'd1);
        check("lock_ready_b3", 32'(bus.req_ready), 32'b0010);
        next();
        check("lock_release_valid", 32'(bus.out_valid), 32'h0);
        check("lock_release_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 4'b1000;
        next();
        check("lock_next_sel", 32'(bus.select_vector[0]), 32'd3);
        check("lock_next_ready", 32'(bus.req_ready), 32'b1000);
        next();
        bus.req_valid = 4'h0;

        // Backpressure on output 1 while locked to input 2.
        bus.req_dest[2] = 2'd1;
        bus.req_last    = 4'b0000;
        bus.out_ready   = 4'b1101;
        bus.req_valid   = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            next();
            check("bp_sel1", 32'(bus.select_vector[1]), 32'd2);
            check("bp_valid1", 32'(bus.out_valid[1]), 32'd1);
            check("bp_ready2", 32'(bus.req_ready[2]), 32'd0);
            check("bp_beats", 32'(beats1), 32'd0);
        end
        bus.out_ready = 4'hF;
        #1;
        check("bp_resume_ready", 32'(bus.req_ready), 32'b0100);
        next();
        check("bp_beats_1", 32'(beats1), 32'd1);
        next();
        check("bp_beats_2", 32'(beats1), 32'd2);
        bus.req_last = 4'b0100;
        next();
        check("bp_beats_3", 32'(beats1), 32'd3);
        check("bp_release_valid", 32'(bus.out_valid[1]), 32'd0);
        bus.req_valid = 4'h0;

        // Two outputs granted independently in the same cycle.
        bus.req_dest[0] = 2'd3;
        bus.req_dest[1] = 2'd0;
        bus.req_last    = 4'b0011;
        bus.req_valid   = 4'b0011;
        next();
        check("par_valid", 32'(bus.out_valid), 32'b1001);
        check("par_sel3", 32'(bus.select_vector[3]), 32'd0);
        check("par_sel0", 32'(bus.select_vector[0]), 32'd1);
        check("par_ready", 32'(bus.req_ready), 32'b0011);
        next();
        bus.req_valid = 4'h0;

        // Reset during beat 2 of a 4-beat packet from input 2 on output 0.
        bus.req_dest[2] = 2'd0;
        bus.req_last    = 4'b0000;
        bus.req_valid   = 4'b0100;
        next();
        check("mid_sel0", 32'(bus.select_vector[0]), 32'd2);
        next();
        rst = 1'b1;
        next();
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_select", 32'(bus.select_vector), 32'h0);
        rst = 1'b0;
        bus.req_dest[1] = 2'd0;
        bus.req_last    = 4'b0110;
        bus.req_valid   = 4'b0110;
        next();
        check("post_rst_sel0", 32'(bus.select_vector[0]), 32'd1);
        check("post_rst_ready", 32'(bus.req_ready), 32'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
